// File: rtl/apb_arb_pkg.sv
// ============================================================================
// apb_arb_pkg : shared types and constants for the APB master arbiter
// rev 1.0
// ============================================================================
`default_nettype none

package apb_arb_pkg;

  localparam int NUM_REQ            = 2;
  localparam int TIMEOUT_CYCLES_DEF = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  typedef logic [$clog2(NUM_REQ)-1:0] owner_t;

endpackage

`default_nettype wire

// File: rtl/apb_arb_rr.sv
// ============================================================================
// apb_arb_rr : combinational 2-way round-robin pick
// rev 1.0
// ============================================================================
`default_nettype none

module apb_arb_rr
  import apb_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  owner_t             last_owner,
  output logic               grant_valid,
  output owner_t             grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = '0;
    // On contention the requester that did not win last time gets the bus.
    if (req[0] && req[1]) begin
      grant_id = ~last_owner;
    end else if (req[1]) begin
      grant_id = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_master_arbiter.sv
// ============================================================================
// apb_master_arbiter : two requesters (CPU=r0, DMA=r1) sharing one APB4 master
// rev 1.0 ; optional ACCESS-phase timeout via macro APB_ARB_TIMEOUT_EN
// ============================================================================
`default_nettype none

module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        pclk,
  input  logic        preset,

  input  logic        r0_req,
  input  logic [31:0] r0_addr,
  input  logic        r0_write,
  input  logic [31:0] r0_wdata,
  input  logic [3:0]  r0_strb,
  output logic        r0_ack,
  output logic [31:0] r0_rdata,
  output logic        r0_slverr,

  input  logic        r1_req,
  input  logic [31:0] r1_addr,
  input  logic        r1_write,
  input  logic [31:0] r1_wdata,
  input  logic [3:0]  r1_strb,
  output logic        r1_ack,
  output logic [31:0] r1_rdata,
  output logic        r1_slverr,

  output logic [31:0] m_paddr,
  output logic        m_psel,
  output logic        m_penable,
  output logic        m_pwrite,
  output logic [31:0] m_pwdata,
  output logic [3:0]  m_pstrb,
  input  logic        m_pready,
  input  logic [31:0] m_prdata,
  input  logic        m_pslverr
);

  state_t      r_state;
  state_t      w_next_state;
  owner_t      r_owner;
  owner_t      r_last_owner;
  owner_t      w_grant_id;
  logic        w_grant_valid;
  logic        w_grant;
  logic        w_timeout;
  logic        w_done;
  logic [31:0] w_rdata;
  logic        w_slverr;

  apb_arb_rr u_rr (
    .req         ({r1_req, r0_req}),
    .last_owner  (r_last_owner),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  assign w_grant = (r_state == IDLE) && w_grant_valid;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant_valid) w_next_state = SETUP;
      SETUP:   w_next_state = ACCESS;
      ACCESS:  if (m_pready || w_timeout) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Payload is captured only at grant, so requester changes mid-transfer are invisible.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_owner      <= '0;
      r_last_owner <= 1'b1;
      m_paddr      <= '0;
      m_pwrite     <= 1'b0;
      m_pwdata     <= '0;
      m_pstrb      <= '0;
    end else if (w_grant) begin
      r_owner      <= w_grant_id;
      r_last_owner <= w_grant_id;
      m_paddr      <= (w_grant_id == 1'b1) ? r1_addr  : r0_addr;
      m_pwrite     <= (w_grant_id == 1'b1) ? r1_write : r0_write;
      m_pwdata     <= (w_grant_id == 1'b1) ? r1_wdata : r0_wdata;
      m_pstrb      <= (w_grant_id == 1'b1) ? r1_strb  : r0_strb;
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_wait_cnt <= '0;
    end else if (w_grant) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ACCESS) && !m_pready) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // The counter holds the number of earlier stalled cycles, so this fires in the Nth one.
  assign w_timeout = (r_state == ACCESS) && !m_pready &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign w_timeout            = 1'b0;
`endif

  assign m_psel    = (r_state != IDLE);
  assign m_penable = (r_state == ACCESS);

  assign w_done   = (r_state == ACCESS) && (m_pready || w_timeout);
  assign w_rdata  = w_timeout ? 32'h0 : m_prdata;
  assign w_slverr = w_timeout | m_pslverr;

  assign r0_ack    = w_done && (r_owner == 1'b0);
  assign r1_ack    = w_done && (r_owner == 1'b1);
  assign r0_rdata  = r0_ack ? w_rdata  : 32'h0;
  assign r1_rdata  = r1_ack ? w_rdata  : 32'h0;
  assign r0_slverr = r0_ack ? w_slverr : 1'b0;
  assign r1_slverr = r1_ack ? w_slverr : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
// ============================================================================
// tb_apb_master_arbiter : scoreboard bench with an APB slave responder
// rev 1.0 ; timeout scenario built only when APB_ARB_TIMEOUT_EN is defined
// ============================================================================
`default_nettype none

module tb_apb_master_arbiter;

  localparam logic [31:0] UNMAPPED = 32'h1000_0000;

  typedef struct {
    logic        owner;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          acc;
    logic [31:0] rdata;
    logic        slverr;
  } item_t;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        r0_req = 1'b0, r1_req = 1'b0;
  logic [31:0] r0_addr = '0, r1_addr = '0, r0_wdata = '0, r1_wdata = '0;
  logic        r0_write = 1'b0, r1_write = 1'b0;
  logic [3:0]  r0_strb = '0, r1_strb = '0;
  logic        r0_ack, r1_ack, r0_slverr, r1_slverr;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] m_paddr, m_pwdata, m_prdata = '0;
  logic        m_psel, m_penable, m_pwrite, m_pready = 1'b0, m_pslverr = 1'b0;
  logic [3:0]  m_pstrb;

  item_t       sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          rem0 = 0, rem1 = 0;
  int          cfg_wait = 0;
  logic        cfg_fixed_en = 1'b0;
  logic [31:0] cfg_prdata = '0;

  apb_master_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .pclk(pclk), .preset(preset),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_write(r0_write), .r0_wdata(r0_wdata),
    .r0_strb(r0_strb), .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_slverr(r0_slverr),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_write(r1_write), .r1_wdata(r1_wdata),
    .r1_strb(r1_strb), .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_slverr(r1_slverr),
    .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_pready(m_pready),
    .m_prdata(m_prdata), .m_pslverr(m_pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic owner, input logic [31:0] addr, input logic write,
                      input logic [31:0] wdata, input logic [3:0] strb, input int acc,
                      input logic [31:0] rdata, input logic slverr);
    item_t it;
    it.owner = owner; it.addr = addr; it.write = write; it.wdata = wdata;
    it.strb = strb; it.acc = acc; it.rdata = rdata; it.slverr = slverr;
    sb.push_back(it);
  endtask

  task automatic set_payload(input int id, input logic [31:0] addr, input logic write,
                             input logic [31:0] wdata, input logic [3:0] strb);
    if (id == 0) begin
      r0_addr = addr; r0_write = write; r0_wdata = wdata; r0_strb = strb;
    end else begin
      r1_addr = addr; r1_write = write; r1_wdata = wdata; r1_strb = strb;
    end
  endtask

  task automatic request(input int id, input int n);
    if (id == 0) begin rem0 = n; r0_req = 1'b1; end
    else         begin rem1 = n; r1_req = 1'b1; end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || r0_req || r1_req) && n < budget) begin
      @(negedge pclk);
      n++;
    end
    #2;
    check("drain_done", (sb.size() == 0) ? 32'd1 : 32'd0, 32'd1);
    sb.delete();
    r0_req = 1'b0; r1_req = 1'b0; rem0 = 0; rem1 = 0;
  endtask

  task automatic apply_reset();
    preset = 1'b1;
    r0_req = 1'b0; r1_req = 1'b0; rem0 = 0; rem1 = 0;
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
  endtask

  // Slave responder plus scoreboard consumer; runs on the falling edge.
  initial begin
    int k = 0;
    item_t it;
    forever begin
      @(negedge pclk);
      if (m_psel && !m_penable) begin
        k = 0; m_pready = 1'b0;
      end else if (m_psel && m_penable) begin
        k++; m_pready = (k > cfg_wait);
      end else begin
        m_pready = 1'b0;
      end
      m_prdata  = cfg_fixed_en ? cfg_prdata : ~m_paddr;
      m_pslverr = (m_paddr == UNMAPPED);
      #1;
      if (m_psel && m_penable && sb.size() != 0) begin
        check("paddr",  m_paddr,  sb[0].addr);
        check("pwrite", m_pwrite, sb[0].write);
        check("pwdata", m_pwdata, sb[0].wdata);
        check("pstrb",  m_pstrb,  sb[0].strb);
      end
      if (r0_ack || r1_ack) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", {r1_ack, r0_ack}, 32'd0);
        end else begin
          it = sb.pop_front();
          check("single_ack", r0_ack & r1_ack, 32'd0);
          check("ack_owner", r1_ack, it.owner);
          check("ack_cycle", k, it.acc);
          if (it.owner == 1'b0) begin
            check("r0_rdata", r0_rdata, it.rdata);
            check("r0_slverr", r0_slverr, it.slverr);
            check("r1_idle_out", {r1_slverr, r1_rdata[30:0]} | {31'd0, r1_rdata[31]}, 32'd0);
            rem0--;
            if (rem0 <= 0) r0_req = 1'b0;
          end else begin
            check("r1_rdata", r1_rdata, it.rdata);
            check("r1_slverr", r1_slverr, it.slverr);
            check("r0_idle_out", {r0_slverr, r0_rdata[30:0]} | {31'd0, r0_rdata[31]}, 32'd0);
            rem1--;
            if (rem1 <= 0) r1_req = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge pclk);
    #1;
    check("rst_psel",    m_psel,    32'd0);
    check("rst_penable", m_penable, 32'd0);
    check("rst_paddr",   m_paddr,   32'd0);
    check("rst_pwdata",  m_pwdata,  32'd0);
    check("rst_pctl",    {m_pwrite, m_pstrb}, 32'd0);
    check("rst_acks",    {r1_ack, r0_ack}, 32'd0);
    preset = 1'b0;
    @(negedge pclk);

    // Minimum-latency read with a fixed read word.
    cfg_wait = 0; cfg_fixed_en = 1'b1; cfg_prdata = 32'hDEAD_BEEF;
    set_payload(0, 32'h0002_8004, 1'b0, 32'h0, 4'h0);
    push(1'b0, 32'h0002_8004, 1'b0, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, 1'b0);
    request(0, 1);
    @(negedge pclk);
    check("t1_psel_pen", {m_psel, m_penable}, 32'b10);
    @(negedge pclk);
    check("t2_psel_pen", {m_psel, m_penable}, 32'b11);
    drain(10);
    check("idle_psel", m_psel, 32'd0);
    check("idle_hold_paddr", m_paddr, 32'h0002_8004);
    cfg_fixed_en = 1'b0;

    // Contention straight after reset: r0 first, then strict alternation.
    apply_reset();
    set_payload(0, 32'h0002_0010, 1'b0, 32'h0, 4'h0);
    set_payload(1, 32'h0002_0020, 1'b1, 32'h1234_5678, 4'hF);
    push(1'b0, 32'h0002_0010, 1'b0, 32'h0, 4'h0, 1, ~32'h0002_0010, 1'b0);
    push(1'b1, 32'h0002_0020, 1'b1, 32'h1234_5678, 4'hF, 1, ~32'h0002_0020, 1'b0);
    push(1'b0, 32'h0002_0010, 1'b0, 32'h0, 4'h0, 1, ~32'h0002_0010, 1'b0);
    push(1'b1, 32'h0002_0020, 1'b1, 32'h1234_5678, 4'hF, 1, ~32'h0002_0020, 1'b0);
    request(0, 2);
    request(1, 2);
    drain(30);

    // Wait-stated r1 write; payload inputs change after grant and must be ignored.
    cfg_wait = 3;
    set_payload(1, 32'h0002_A000, 1'b1, 32'h0000_00A5, 4'h1);
    push(1'b1, 32'h0002_A000, 1'b1, 32'h0000_00A5, 4'h1, 4, ~32'h0002_A000, 1'b0);
    request(1, 1);
    @(negedge pclk);
    check("grant_psel", m_psel, 32'd1);
    set_payload(1, 32'hFFFF_0000, 1'b0, 32'h5A5A_5A5A, 4'hE);
    drain(20);
    cfg_wait = 0;

    // Error response from an unmapped address.
    set_payload(0, UNMAPPED, 1'b0, 32'h0, 4'h0);
    push(1'b0, UNMAPPED, 1'b0, 32'h0, 4'h0, 1, ~UNMAPPED, 1'b1);
    request(0, 1);
    drain(10);

    // Reset in the middle of ACCESS drops the transfer without an ack.
    cfg_wait = 5;
    set_payload(0, 32'h0002_8008, 1'b1, 32'hCAFE_F00D, 4'hF);
    r0_req = 1'b1;
    n = 0;
    while (!(m_psel && m_penable) && n < 10) begin
      @(negedge pclk);
      n++;
    end
    check("reached_access", {m_psel, m_penable}, 32'b11);
    #2 preset = 1'b1;
    #1;
    check("rst_mid_psel_pen", {m_psel, m_penable}, 32'd0);
    check("rst_mid_paddr", m_paddr, 32'd0);
    r0_req = 1'b0;
    @(negedge pclk);
    preset = 1'b0;
    repeat (4) @(negedge pclk);
    #2;
    check("post_rst_idle", {m_psel, r1_ack, r0_ack}, 32'd0);
    cfg_wait = 0;
    set_payload(1, 32'h0002_0044, 1'b0, 32'h0, 4'h0);
    push(1'b1, 32'h0002_0044, 1'b0, 32'h0, 4'h0, 1, ~32'h0002_0044, 1'b0);
    request(1, 1);
    drain(10);

`ifdef APB_ARB_TIMEOUT_EN
    // Slave never responds: error ack with zero data in the 8th ACCESS cycle.
    cfg_wait = 1000;
    set_payload(0, 32'h0002_0050, 1'b0, 32'h0, 4'h0);
    push(1'b0, 32'h0002_0050, 1'b0, 32'h0, 4'h0, 8, 32'h0, 1'b1);
    request(0, 1);
    drain(30);
    check("to_idle_psel", m_psel, 32'd0);
    cfg_wait = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
